perf_counter_controller: RTL and testbench

Programmable performance-counter controller that sits between the per-stage event sources (fetch, decode, memory tag access, store commit, recovery) and the CSR unit. It maps a configurable set of event lines onto NUM_COUNTERS hardware counters, handles CSR reads and writes of those counters, and applies inhibit and global freeze. It also takes an atomic snapshot of all counters and streams that snapshot to a debug sink over a valid/ready handshake.

---
 rtl/perf_counter_controller.sv | 137 +++++++++++++
 tb/tb_perf_counter_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_controller.sv
// Performance-counter controller: event-selected counters with CSR access, inhibit/freeze,
// sticky overflow, and an atomic snapshot streamed to a debug sink over valid/ready.
module perf_counter_controller #(
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_EVENTS    = 8,
    parameter int unsigned SEL_WIDTH     = $clog2(NUM_EVENTS),
    localparam int unsigned IDX_WIDTH    = $clog2(NUM_COUNTERS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_EVENTS-1:0]    eventIn,
    input  logic                     freeze,
    input  logic                     cfgWe,
    input  logic [1:0]               cfgKind,
    input  logic [IDX_WIDTH-1:0]     cfgIdx,
    input  logic [COUNTER_WIDTH-1:0] cfgData,
    input  logic [IDX_WIDTH-1:0]     rdIdx,
    output logic [COUNTER_WIDTH-1:0] rdData,
    output logic [NUM_COUNTERS-1:0]  overflow,
    input  logic                     snapReq,
    output logic                     snapBusy,
    output logic                     dumpValid,
    input  logic                     dumpReady,
    output logic [IDX_WIDTH-1:0]     dumpIdx,
    output logic [COUNTER_WIDTH-1:0] dumpData
);

    localparam logic [1:0] KIND_VALUE   = 2'd0;
    localparam logic [1:0] KIND_SELECT  = 2'd1;
    localparam logic [1:0] KIND_INHIBIT = 2'd2;
    localparam logic [1:0] KIND_CLEAR   = 2'd3;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COUNTERS - 1);

    typedef enum logic [0:0] {StIdle, StDump} state_e;

    state_e                   state_q;
    logic [COUNTER_WIDTH-1:0] cnt_q    [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d    [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] shadow_q [NUM_COUNTERS];
    logic [SEL_WIDTH-1:0]     sel_q    [NUM_COUNTERS];
    logic [SEL_WIDTH-1:0]     sel_d    [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  inhibit_q, inhibit_d;
    logic [NUM_COUNTERS-1:0]  ovf_d;
    logic [IDX_WIDTH-1:0]     next_idx;

    assign rdData   = cnt_q[rdIdx];
    assign next_idx = dumpIdx + IDX_WIDTH'(1);

    always_comb begin
        logic hit;
        logic inc;
        hit = 1'b0;
        inc = 1'b0;
        inhibit_d = inhibit_q;
        if (cfgWe && cfgKind == KIND_INHIBIT) begin
            inhibit_d = cfgData[NUM_COUNTERS-1:0];
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            hit      = cfgWe && (cfgIdx == IDX_WIDTH'(i));
            inc      = eventIn[sel_q[i]] && !inhibit_q[i] && !freeze;
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
            ovf_d[i] = overflow[i];
            if (hit && cfgKind == KIND_SELECT) begin
                sel_d[i] = (cfgData < COUNTER_WIDTH'(NUM_EVENTS)) ? cfgData[SEL_WIDTH-1:0] : '0;
            end
            if (hit && cfgKind == KIND_CLEAR) begin
                ovf_d[i] = 1'b0;
            end
            // A value write wins over the event; a wrap wins over a clear.
            if (hit && cfgKind == KIND_VALUE) begin
                cnt_d[i] = cfgData;
            end else if (inc) begin
                cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '{default: '0};
            sel_q     <= '{default: '0};
            inhibit_q <= '0;
            overflow  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            inhibit_q <= inhibit_d;
            overflow  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shadow_q  <= '{default: '0};
            snapBusy  <= 1'b0;
            dumpValid <= 1'b0;
            dumpIdx   <= '0;
            dumpData  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Capture post-update values so the snapshot matches what rdData shows next.
                    if (snapReq) begin
                        shadow_q  <= cnt_d;
                        state_q   <= StDump;
                        snapBusy  <= 1'b1;
                        dumpValid <= 1'b1;
                        dumpIdx   <= '0;
                        dumpData  <= cnt_d[0];
                    end
                end
                StDump: begin
                    if (dumpReady) begin
                        if (dumpIdx == LAST_IDX) begin
                            state_q   <= StIdle;
                            snapBusy  <= 1'b0;
                            dumpValid <= 1'b0;
                            dumpIdx   <= '0;
                            dumpData  <= '0;
                        end else begin
                            dumpIdx  <= next_idx;
                            dumpData <= shadow_q[next_idx];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_controller.sv
// Bench for perf_counter_controller: cycle model for counters, queue scoreboard for dump beats.
module tb_perf_counter_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  eventIn;
    logic        freeze;
    logic        cfgWe;
    logic [1:0]  cfgKind;
    logic [1:0]  cfgIdx;
    logic [63:0] cfgData;
    logic [1:0]  rdIdx;
    logic [63:0] rdData;
    logic [3:0]  overflow;
    logic        snapReq;
    logic        snapBusy;
    logic        dumpValid;
    logic        dumpReady;
    logic [1:0]  dumpIdx;
    logic [63:0] dumpData;

    perf_counter_controller dut (
        .clk       (clk),
        .rst       (rst),
        .eventIn   (eventIn),
        .freeze    (freeze),
        .cfgWe     (cfgWe),
        .cfgKind   (cfgKind),
        .cfgIdx    (cfgIdx),
        .cfgData   (cfgData),
        .rdIdx     (rdIdx),
        .rdData    (rdData),
        .overflow  (overflow),
        .snapReq   (snapReq),
        .snapBusy  (snapBusy),
        .dumpValid (dumpValid),
        .dumpReady (dumpReady),
        .dumpIdx   (dumpIdx),
        .dumpData  (dumpData)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] data;
    } beat_t;

    logic [63:0] m_cnt [4];
    logic [2:0]  m_sel [4];
    logic [3:0]  m_inh;
    logic [3:0]  m_ovf;
    logic        m_busy;
    int          m_beat;
    beat_t       sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs held across that edge.
    task automatic model_step();
        logic [63:0] n_cnt [4];
        logic [2:0]  n_sel [4];
        logic [3:0]  n_ovf;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_cnt[k] = '0;
                m_sel[k] = '0;
            end
            m_inh  = '0;
            m_ovf  = '0;
            m_busy = 1'b0;
            m_beat = 0;
            sb.delete();
            return;
        end
        n_ovf = m_ovf;
        for (int k = 0; k < 4; k++) begin
            logic fire;
            logic wrap;
            logic tgt;
            tgt  = cfgWe && (int'(cfgIdx) == k);
            fire = eventIn[m_sel[k]] && !m_inh[k] && !freeze;
            wrap = 1'b0;
            n_cnt[k] = m_cnt[k];
            n_sel[k] = m_sel[k];
            if (tgt && cfgKind == 2'd0) begin
                n_cnt[k] = cfgData;
            end else if (fire) begin
                if (m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) begin
                    n_cnt[k] = 64'd0;
                    wrap = 1'b1;
                end else begin
                    n_cnt[k] = m_cnt[k] + 64'd1;
                end
            end
            if (tgt && cfgKind == 2'd1) n_sel[k] = (cfgData < 64'd8) ? cfgData[2:0] : 3'd0;
            if (tgt && cfgKind == 2'd3) n_ovf[k] = 1'b0;
            if (wrap) n_ovf[k] = 1'b1;
        end
        if (!m_busy && snapReq) begin
            for (int k = 0; k < 4; k++) sb.push_back(beat_t'{idx: 2'(k), data: n_cnt[k]});
            m_busy = 1'b1;
            m_beat = 0;
        end else if (m_busy && dumpReady) begin
            if (m_beat == 3) m_busy = 1'b0;
            else m_beat++;
        end
        if (cfgWe && cfgKind == 2'd2) m_inh = cfgData[3:0];
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = n_cnt[k];
            m_sel[k] = n_sel[k];
        end
        m_ovf = n_ovf;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 4; k++) begin
            rdIdx = 2'(k);
            #1;
            check($sformatf("cnt%0d", k), rdData, m_cnt[k]);
        end
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic csr(input logic [1:0] kind, input logic [1:0] idx, input logic [63:0] data);
        cfgWe   = 1'b1;
        cfgKind = kind;
        cfgIdx  = idx;
        cfgData = data;
        cycle();
        cfgWe   = 1'b0;
    endtask

    task automatic expect_cnt(input string tag, input int k, input logic [63:0] val);
        rdIdx = 2'(k);
        #1;
        check(tag, rdData, val);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("dumpValid", 64'(dumpValid), 64'(m_busy));
            check("snapBusy", 64'(snapBusy), 64'(m_busy));
            if (m_busy && sb.size() > 0) begin
                check("dumpIdx", 64'(dumpIdx), 64'(sb[0].idx));
                check("dumpData", dumpData, sb[0].data);
            end
            if (dumpValid && dumpReady) begin
                if (sb.size() > 0) void'(sb.pop_front());
                else check("unexpected_beat", 64'(dumpValid), 64'(0));
            end
        end
    end

    initial begin
        rst = 1'b1; eventIn = '0; freeze = 1'b0; cfgWe = 1'b0; cfgKind = '0; cfgIdx = '0;
        cfgData = '0; rdIdx = '0; snapReq = 1'b0; dumpReady = 1'b0;
        m_busy = 1'b0; m_beat = 0; m_inh = '0; m_ovf = '0;
        cycle();
        cycle();
        mon_en = 1'b1;
        check("rst_dumpValid", 64'(dumpValid), 64'(0));
        check("rst_snapBusy", 64'(snapBusy), 64'(0));
        check("rst_dumpIdx", 64'(dumpIdx), 64'(0));
        check("rst_dumpData", dumpData, 64'd0);
        rst = 1'b0;

        // Cycle event on every counter.
        eventIn = 8'h01;
        repeat (10) cycle();
        for (int k = 0; k < 4; k++) expect_cnt("t1_cnt", k, 64'd10);
        check("t1_ovf", 64'(overflow), 64'(0));

        // Select and inhibit.
        eventIn = 8'h00;
        csr(2'd1, 2'd1, 64'd3);
        csr(2'd2, 2'd0, 64'd4);
        csr(2'd0, 2'd1, 64'd0);
        repeat (5) begin
            eventIn = 8'h09;
            cycle();
            eventIn = 8'h01;
            cycle();
        end
        expect_cnt("t2_cnt0", 0, 64'd20);
        expect_cnt("t2_cnt1", 1, 64'd5);
        expect_cnt("t2_cnt2", 2, 64'd10);

        // Out-of-range select, wrap, sticky overflow, clear, clear-vs-wrap.
        eventIn = 8'h00;
        csr(2'd1, 2'd3, 64'd13);
        csr(2'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        eventIn = 8'h01;
        cycle();
        cycle();
        expect_cnt("t3_wrap", 3, 64'd0);
        check("t3_ovf_set", 64'(overflow), 64'h8);
        eventIn = 8'h00;
        csr(2'd3, 2'd3, 64'd0);
        check("t3_ovf_clr", 64'(overflow), 64'h0);
        csr(2'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        eventIn = 8'h01;
        csr(2'd3, 2'd3, 64'd0);
        check("t3_ovf_race", 64'(overflow), 64'h8);
        expect_cnt("t3_wrap2", 3, 64'd0);
        eventIn = 8'h00;
        csr(2'd3, 2'd3, 64'd0);

        // Write priority over a same-cycle event, then freeze.
        eventIn = 8'h01;
        csr(2'd0, 2'd0, 64'd100);
        expect_cnt("t4_wr", 0, 64'd100);
        cycle();
        expect_cnt("t4_inc", 0, 64'd101);
        freeze = 1'b1;
        cycle();
        expect_cnt("t4_freeze", 0, 64'd101);
        freeze = 1'b0;

        // Snapshot with a stall and an ignored second request.
        eventIn = 8'h00;
        csr(2'd0, 2'd0, 64'd5);
        csr(2'd0, 2'd1, 64'd6);
        csr(2'd0, 2'd2, 64'd7);
        cfgWe = 1'b1; cfgKind = 2'd0; cfgIdx = 2'd3; cfgData = 64'd8; snapReq = 1'b1;
        cycle();
        cfgWe = 1'b0; snapReq = 1'b0;
        check("snap_valid", 64'(dumpValid), 64'(1));
        check("snap_busy", 64'(snapBusy), 64'(1));
        check("snap_idx0", 64'(dumpIdx), 64'(0));
        check("snap_data0", dumpData, 64'd5);
        eventIn = 8'h01;
        dumpReady = 1'b1;
        cycle();
        dumpReady = 1'b0;
        snapReq = 1'b1;
        cycle();
        snapReq = 1'b0;
        check("stall_idx", 64'(dumpIdx), 64'(1));
        check("stall_data", dumpData, 64'd6);
        dumpReady = 1'b1;
        cycle();
        check("beat2_data", dumpData, 64'd7);
        cycle();
        check("beat3_data", dumpData, 64'd8);
        cycle();
        check("done_valid", 64'(dumpValid), 64'(0));
        check("done_busy", 64'(snapBusy), 64'(0));

        // Back-to-back request right after snapBusy falls.
        snapReq = 1'b1;
        cycle();
        snapReq = 1'b0;
        check("b2b_valid", 64'(dumpValid), 64'(1));
        repeat (4) cycle();
        check("b2b_done", 64'(dumpValid), 64'(0));
        check("b2b_drained", 64'(sb.size()), 64'(0));

        // Reset in the middle of a dump.
        dumpReady = 1'b0;
        snapReq = 1'b1;
        cycle();
        snapReq = 1'b0;
        dumpReady = 1'b1;
        cycle();
        dumpReady = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_valid", 64'(dumpValid), 64'(0));
        check("mid_rst_busy", 64'(snapBusy), 64'(0));
        for (int k = 0; k < 4; k++) expect_cnt("mid_rst_cnt", k, 64'd0);
        cycle();
        expect_cnt("post_rst_inh", 2, 64'd1);
        eventIn = 8'h00;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
